// File: rtl/ternary_pkg.sv
// Balanced-ternary trit encoding and single-trit arithmetic helpers
// shared by the Tritone adder datapath.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_NEG  = 2'b00;
    localparam trit_t T_ZERO = 2'b01;
    localparam trit_t T_POS  = 2'b10;
    localparam trit_t T_INV  = 2'b11;

    function automatic trit_t trit_neg(input trit_t t);
        trit_t r;
        r = t;
        if (t == T_NEG) r = T_POS;
        if (t == T_POS) r = T_NEG;
        return r;
    endfunction

    function automatic trit_t trit_sanitize(input trit_t t, output logic bad);
        bad = (t == T_INV);
        return bad ? T_ZERO : t;
    endfunction

    // Encoding is value+1, so the raw sum of three codes is the value sum offset by 3.
    function automatic logic [3:0] btfa(input trit_t a, input trit_t b, input trit_t c);
        logic [2:0] t;
        logic [3:0] r;
        t = {1'b0, a} + {1'b0, b} + {1'b0, c};
        unique case (t)
            3'd0:    r = {T_NEG,  T_ZERO};
            3'd1:    r = {T_NEG,  T_POS};
            3'd2:    r = {T_ZERO, T_NEG};
            3'd4:    r = {T_ZERO, T_POS};
            3'd5:    r = {T_POS,  T_NEG};
            3'd6:    r = {T_POS,  T_ZERO};
            default: r = {T_ZERO, T_ZERO};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ternary_pipe_adder_seg.sv
// Combinational SEG_TRITS-trit balanced-ternary ripple adder segment.
module ternary_seg_adder
    import ternary_pkg::*;
#(
    parameter int SEG_TRITS = 2
) (
    input  logic [2*SEG_TRITS-1:0] a,
    input  logic [2*SEG_TRITS-1:0] b,
    input  trit_t                  cin,
    output logic [2*SEG_TRITS-1:0] sum,
    output trit_t                  cout
);

    always_comb begin
        trit_t      c;
        logic [3:0] r;
        c   = cin;
        r   = '0;
        sum = '0;
        for (int i = 0; i < SEG_TRITS; i++) begin
            r              = btfa(a[2*i +: 2], b[2*i +: 2], c);
            sum[2*i +: 2]  = r[1:0];
            c              = r[3:2];
        end
        cout = c;
    end

endmodule

// File: rtl/ternary_pipe_adder.sv
// Pipelined balanced-ternary add/subtract: one trit segment per stage,
// carry registered between stages, valid/ready flow control end to end.
module ternary_pipe_adder
    import ternary_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SEG_TRITS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [2*WIDTH-1:0] in_a,
    input  logic [2*WIDTH-1:0] in_b,
    input  trit_t              in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_sum,
    output trit_t              out_cout,
    output logic               out_ovf,
    output logic               out_err
);

    localparam int NSEG = WIDTH / SEG_TRITS;
    localparam int SW   = 2 * SEG_TRITS;
    localparam int W2   = 2 * WIDTH;

    logic [NSEG:0] v;
    logic [NSEG:0] adv;
    logic          load;
    trit_t         c [0:NSEG];
    logic          e [0:NSEG];
    logic [W2-1:0] s [0:NSEG];
    logic [W2-1:0] a [0:NSEG-1];
    logic [W2-1:0] b [0:NSEG-1];

    logic [SW-1:0] seg_sum  [0:NSEG-1];
    trit_t         seg_cout [0:NSEG-1];

    logic [W2-1:0] ent_a;
    logic [W2-1:0] ent_b;
    trit_t         ent_cin;
    logic          ent_err;

    always_comb begin
        logic  bad;
        trit_t tb;
        bad     = 1'b0;
        tb      = T_ZERO;
        ent_a   = '0;
        ent_b   = '0;
        ent_err = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            ent_a[2*i +: 2] = trit_sanitize(in_a[2*i +: 2], bad);
            ent_err         = ent_err | bad;
            tb              = trit_sanitize(in_b[2*i +: 2], bad);
            ent_err         = ent_err | bad;
            ent_b[2*i +: 2] = in_mode ? trit_neg(tb) : tb;
        end
        ent_cin = trit_sanitize(in_cin, bad);
        ent_err = ent_err | bad;
    end

    // Walk back from the output: a slot is free when empty or its occupant moves on.
    always_comb begin
        logic f;
        logic nf;
        f   = out_ready;
        nf  = 1'b0;
        adv = '0;
        for (int k = NSEG; k >= 0; k--) begin
            nf     = ~v[k] | f;
            adv[k] = v[k] & f;
            f      = nf;
        end
        in_ready = f;
    end

    assign load = in_valid & in_ready;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        ternary_seg_adder #(.SEG_TRITS(SEG_TRITS)) u_add (
            .a    (a[k][k*SW +: SW]),
            .b    (b[k][k*SW +: SW]),
            .cin  (c[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k <= NSEG; k++) begin
                c[k] <= T_ZERO;
                e[k] <= 1'b0;
                s[k] <= {WIDTH{T_ZERO}};
            end
            for (int k = 0; k < NSEG; k++) begin
                a[k] <= {WIDTH{T_ZERO}};
                b[k] <= {WIDTH{T_ZERO}};
            end
        end else begin
            v[0] <= load | (v[0] & ~adv[0]);
            if (load) begin
                a[0] <= ent_a;
                b[0] <= ent_b;
                c[0] <= ent_cin;
                e[0] <= ent_err;
            end
            for (int k = 0; k < NSEG; k++) begin
                v[k+1] <= adv[k] | (v[k+1] & ~adv[k+1]);
                if (adv[k]) begin
                    c[k+1]                <= seg_cout[k];
                    e[k+1]                <= e[k];
                    s[k+1]                <= s[k];
                    s[k+1][k*SW +: SW]    <= seg_sum[k];
                end
            end
            for (int k = 1; k < NSEG; k++) begin
                if (adv[k-1]) begin
                    a[k] <= a[k-1];
                    b[k] <= b[k-1];
                end
            end
        end
    end

    assign out_valid = v[NSEG];
    assign out_sum   = s[NSEG];
    assign out_cout  = c[NSEG];
    assign out_err   = e[NSEG];
    assign out_ovf   = (c[NSEG] != T_ZERO);

endmodule

// File: tb/tb_ternary_pipe_adder.sv
// Scoreboard bench for ternary_pipe_adder (WIDTH=4, SEG_TRITS=2) with an
// integer-arithmetic reference model.
module tb_ternary_pipe_adder;
    import ternary_pkg::*;

    localparam int W    = 4;
    localparam int SEG  = 2;
    localparam int NSEG = W / SEG;
    localparam int LIM  = 40;
    localparam int MOD  = 81;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_mode;
    logic [2*W-1:0] in_a;
    logic [2*W-1:0] in_b;
    logic [1:0]     in_cin;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_sum;
    logic [1:0]     out_cout;
    logic           out_ovf;
    logic           out_err;

    ternary_pipe_adder #(.WIDTH(W), .SEG_TRITS(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] sum;
        logic [1:0]     cout;
        logic           err;
        int             acc;
        bit             chk;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int   cmp = 0;
    int   bad = 0;
    int   cyc = 0;
    int   occ = 0;
    int   lo = -1;
    int   hi = -1;
    bit   rnd_rdy = 0;
    bit   saw_full = 0;

    function automatic int tval(input logic [1:0] t);
        return (t == 2'b11) ? 0 : int'(t) - 1;
    endfunction

    function automatic logic [2*W-1:0] enc(input int v);
        logic [2*W-1:0] r;
        int d;
        r = '0;
        for (int i = 0; i < W; i++) begin
            d = ((v % 3) + 3) % 3;
            if (d == 2) d = -1;
            r[2*i +: 2] = 2'(d + 1);
            v = (v - d) / 3;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                   input logic [1:0] ci, input logic m);
        exp_t r;
        int x;
        int co;
        bit e;
        x = tval(ci);
        e = (ci == 2'b11);
        for (int i = 0; i < W; i++) begin
            x += tval(a[2*i +: 2]) * (3 ** i);
            x += (m ? -1 : 1) * tval(b[2*i +: 2]) * (3 ** i);
            e |= (a[2*i +: 2] == 2'b11) || (b[2*i +: 2] == 2'b11);
        end
        co = (x > LIM) ? 1 : (x < -LIM) ? -1 : 0;
        r.sum  = enc(x - MOD * co);
        r.cout = 2'(co + 1);
        r.err  = e;
        r.acc  = 0;
        r.chk  = 0;
        return r;
    endfunction

    function automatic logic [2*W-1:0] rtrits();
        logic [2*W-1:0] r;
        int u;
        r = '0;
        for (int i = 0; i < W; i++) begin
            u = int'($urandom % 13);
            r[2*i +: 2] = (u == 12) ? 2'b11 : 2'(u % 3);
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        out_ready = rnd_rdy ? (($urandom % 4) != 0) : !(cyc >= lo && cyc <= hi);

    logic [2*W-1:0] psum;
    logic [1:0]     pcout;
    logic           perr;
    logic           povf;
    bit             pstall = 0;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            pstall = 0;
        end else begin
            cmp++;
            if (in_ready !== ((occ < NSEG + 1) || out_ready)) begin
                bad++;
                $display("FAIL in_ready: got %b want %b (occ=%0d out_ready=%b)",
                         in_ready, (occ < NSEG + 1) || out_ready, occ, out_ready);
            end
            if (!in_ready) saw_full = 1;
            if (pstall) begin
                cmp++;
                if (out_valid !== 1'b1 || out_sum !== psum || out_cout !== pcout ||
                    out_err !== perr || out_ovf !== povf) begin
                    bad++;
                    $display("FAIL hold: got v=%b sum=%h cout=%h want v=1 sum=%h cout=%h",
                             out_valid, out_sum, out_cout, psum, pcout);
                end
            end
            if (out_valid && out_ready) begin
                cmp++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected: got sum=%h cout=%h with empty scoreboard",
                             out_sum, out_cout);
                end else begin
                    mx = q.pop_front();
                    if ({out_sum, out_cout, out_err, out_ovf} !==
                        {mx.sum, mx.cout, mx.err, mx.cout != T_ZERO}) begin
                        bad++;
                        $display("FAIL result: got sum=%h cout=%h err=%b ovf=%b want sum=%h cout=%h err=%b ovf=%b",
                                 out_sum, out_cout, out_err, out_ovf,
                                 mx.sum, mx.cout, mx.err, mx.cout != T_ZERO);
                    end
                    if (mx.chk) begin
                        cmp++;
                        if (cyc - mx.acc != NSEG) begin
                            bad++;
                            $display("FAIL latency: got %0d want %0d", cyc - mx.acc, NSEG);
                        end
                    end
                end
            end
            pstall = out_valid && !out_ready;
            psum   = out_sum;
            pcout  = out_cout;
            perr   = out_err;
            povf   = out_ovf;
            occ    = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
        end
    end

    task automatic beat(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                        input logic [1:0] ci, input logic m, input bit chk);
        exp_t x;
        bit   done;
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            in_cin   = ci;
            in_mode  = m;
            #1;
            if (in_ready) begin
                x     = model(a, b, ci, m);
                x.acc = cyc + 1;
                x.chk = chk;
                q.push_back(x);
                done  = 1;
            end
        end
        if (!done) begin
            cmp++;
            bad++;
            $display("FAIL accept: in_ready stuck low for 50 cycles");
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
        cmp++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d beats still pending want 0", q.size());
        end
        idle(2);
    endtask

    task automatic chk_rst(input string n);
        cmp++;
        if (out_valid !== 1'b0 || out_sum !== {W{T_ZERO}} || out_cout !== T_ZERO ||
            out_ovf !== 1'b0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL %s: got v=%b sum=%h cout=%h ovf=%b err=%b want v=0 sum=%h cout=%h ovf=0 err=0",
                     n, out_valid, out_sum, out_cout, out_ovf, out_err, {W{T_ZERO}}, T_ZERO);
        end
    endtask

    initial begin
        logic [2*W-1:0] inv_a;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_cin   = T_ZERO;
        repeat (2) @(negedge clk);
        #1;
        chk_rst("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        beat(enc(13), enc(1), T_ZERO, 1'b0, 1);
        beat(enc(40), enc(1), T_ZERO, 1'b0, 1);
        beat(enc(0), enc(5), T_ZERO, 1'b1, 1);
        beat(enc(-40), enc(40), T_ZERO, 1'b1, 1);
        inv_a = enc(0);
        inv_a[1:0] = 2'b11;
        beat(inv_a, enc(1), T_ZERO, 1'b0, 1);
        beat(enc(7), enc(-3), 2'b11, 1'b0, 1);
        beat(enc(-40), enc(-40), T_NEG, 1'b0, 1);
        beat(enc(20), enc(-20), T_POS, 1'b1, 1);
        drain();

        lo = cyc + 3;
        hi = cyc + 6;
        for (int i = 0; i < 6; i++) beat(enc(i), enc(1), T_ZERO, 1'b0, 0);
        drain();
        lo = -1;
        hi = -1;
        cmp++;
        if (!saw_full) begin
            bad++;
            $display("FAIL backpressure: in_ready never dropped got 0 want 1");
        end

        lo = cyc + 1;
        hi = cyc + 1000;
        for (int i = 0; i < 3; i++) beat(enc(10 + i), enc(2), T_ZERO, 1'b0, 0);
        idle(3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_rst("reset_midstream");
        q.delete();
        occ = 0;
        lo  = -1;
        hi  = -1;
        @(negedge clk);
        rst_n = 1'b1;
        beat(enc(-7), enc(2), T_POS, 1'b0, 1);
        drain();

        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 5 == 0) idle(1);
            else beat(rtrits(), rtrits(), 2'($urandom % 4), 1'($urandom % 2), 0);
        end
        drain();
        rnd_rdy = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
